// File: rtl/ffstdp_weight_sweep_if.sv
`default_nettype none
// ============================================================================
// Module   : ffstdp_weight_sweep_if
// Brief    : Start/status, count-memory, synapse-SRAM and update-unit bus
//            of the FF-STDP weight sweep sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface ffstdp_weight_sweep_if #(
  parameter int PRE_ADDR_W     = 8,
  parameter int POST_ADDR_W    = 4,
  parameter int PRE_CNT_WIDTH  = 8,
  parameter int POST_CNT_WIDTH = 7,
  parameter int WEIGHT_WIDTH   = 8
);
  logic                              start_i;
  logic                              is_pos_in_i;
  logic                              is_train_in_i;
  logic                              busy_o;
  logic                              done_o;

  logic                              post_cnt_re_o;
  logic [POST_ADDR_W-1:0]            post_cnt_addr_o;
  logic [POST_CNT_WIDTH-1:0]         post_cnt_rdata_i;

  logic                              pre_cnt_re_o;
  logic [PRE_ADDR_W-1:0]             pre_cnt_addr_o;
  logic [PRE_CNT_WIDTH-1:0]          pre_cnt_rdata_i;

  logic                              syn_cs_o;
  logic                              syn_we_o;
  logic [POST_ADDR_W+PRE_ADDR_W-1:0] syn_addr_o;
  logic [WEIGHT_WIDTH-1:0]           syn_wdata_o;
  logic [WEIGHT_WIDTH-1:0]           syn_rdata_i;

  logic                              upd_tref_event_o;
  logic                              upd_is_pos_o;
  logic                              upd_is_train_o;
  logic [PRE_CNT_WIDTH-1:0]          upd_pre_cnt_o;
  logic [POST_CNT_WIDTH-1:0]         upd_post_cnt_o;
  logic [WEIGHT_WIDTH-1:0]           upd_wsyn_curr_o;
  logic [WEIGHT_WIDTH-1:0]           upd_wsyn_new_i;

  modport master (
    input  start_i, is_pos_in_i, is_train_in_i,
    output busy_o, done_o,
    output post_cnt_re_o, post_cnt_addr_o,
    input  post_cnt_rdata_i,
    output pre_cnt_re_o, pre_cnt_addr_o,
    input  pre_cnt_rdata_i,
    output syn_cs_o, syn_we_o, syn_addr_o, syn_wdata_o,
    input  syn_rdata_i,
    output upd_tref_event_o, upd_is_pos_o, upd_is_train_o,
    output upd_pre_cnt_o, upd_post_cnt_o, upd_wsyn_curr_o,
    input  upd_wsyn_new_i
  );

  modport slave (
    output start_i, is_pos_in_i, is_train_in_i,
    input  busy_o, done_o,
    input  post_cnt_re_o, post_cnt_addr_o,
    output post_cnt_rdata_i,
    input  pre_cnt_re_o, pre_cnt_addr_o,
    output pre_cnt_rdata_i,
    input  syn_cs_o, syn_we_o, syn_addr_o, syn_wdata_o,
    output syn_rdata_i,
    input  upd_tref_event_o, upd_is_pos_o, upd_is_train_o,
    input  upd_pre_cnt_o, upd_post_cnt_o, upd_wsyn_curr_o,
    output upd_wsyn_new_i
  );
endinterface
`default_nettype wire

// File: rtl/ffstdp_weight_sweep.sv
`default_nettype none
// ============================================================================
// Module   : ffstdp_weight_sweep
// Brief    : Walks every (post, pre) synapse after a training sample and
//            writes the FF-STDP update result back to synapse SRAM.
//            Optional FFSTDP_SKIP_ZERO_EN: skip rows/writes with zero counts.
// Revision : 1.0 - initial release
// ============================================================================
module ffstdp_weight_sweep #(
  parameter int PRE_ADDR_W     = 8,
  parameter int N_POST         = 10,
  parameter int POST_ADDR_W    = 4,
  parameter int PRE_CNT_WIDTH  = 8,
  parameter int POST_CNT_WIDTH = 7,
  parameter int WEIGHT_WIDTH   = 8
) (
  input wire                    clk,
  input wire                    rst,
  ffstdp_weight_sweep_if.master bus
);

  localparam logic [PRE_ADDR_W-1:0]  LAST_PRE  = '1;
  localparam logic [POST_ADDR_W-1:0] LAST_POST = POST_ADDR_W'(N_POST - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_POST  = 3'd1,
    S_LAT_POST = 3'd2,
    S_RD       = 3'd3,
    S_WR       = 3'd4,
    S_FIN      = 3'd5
  } state_t;

  typedef struct packed {
    logic busy;
    logic done;
    logic post_re;
    logic rd;
    logic wr;
  } strobe_t;

  // Strobes are registered together with the state so outputs come straight from flops.
  function automatic strobe_t decode(input state_t s);
    strobe_t o;
    o = '0;
    case (s)
      S_RD_POST:  begin o.busy = 1'b1; o.post_re = 1'b1; end
      S_LAT_POST: o.busy = 1'b1;
      S_RD:       begin o.busy = 1'b1; o.rd = 1'b1; end
      S_WR:       begin o.busy = 1'b1; o.wr = 1'b1; end
      S_FIN:      o.done = 1'b1;
      default:    o = '0;
    endcase
    return o;
  endfunction

  state_t                    state_q;
  strobe_t                   strb_q;
  logic [POST_ADDR_W-1:0]    post_idx_q;
  logic [PRE_ADDR_W-1:0]     pre_idx_q;
  logic [POST_CNT_WIDTH-1:0] post_cnt_q;
  logic                      is_pos_q;

  logic                      wr_en;
  logic                      wr_fire;
  logic                      syn_cs;

`ifdef FFSTDP_SKIP_ZERO_EN
  assign wr_en = (bus.pre_cnt_rdata_i != '0);
`else
  assign wr_en = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      strb_q     <= '0;
      post_idx_q <= '0;
      pre_idx_q  <= '0;
      post_cnt_q <= '0;
      is_pos_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start_i) begin
            is_pos_q   <= bus.is_pos_in_i;
            post_idx_q <= '0;
            pre_idx_q  <= '0;
            if (bus.is_train_in_i) begin
              state_q <= S_RD_POST;
              strb_q  <= decode(S_RD_POST);
            end else begin
              state_q <= S_FIN;
              strb_q  <= decode(S_FIN);
            end
          end
        end
        S_RD_POST: begin
          state_q <= S_LAT_POST;
          strb_q  <= decode(S_LAT_POST);
        end
        S_LAT_POST: begin
          post_cnt_q <= bus.post_cnt_rdata_i;
          pre_idx_q  <= '0;
`ifdef FFSTDP_SKIP_ZERO_EN
          if (bus.post_cnt_rdata_i == '0) begin
            if (post_idx_q == LAST_POST) begin
              state_q <= S_FIN;
              strb_q  <= decode(S_FIN);
            end else begin
              post_idx_q <= post_idx_q + 1'b1;
              state_q    <= S_RD_POST;
              strb_q     <= decode(S_RD_POST);
            end
          end else begin
            state_q <= S_RD;
            strb_q  <= decode(S_RD);
          end
`else
          state_q <= S_RD;
          strb_q  <= decode(S_RD);
`endif
        end
        S_RD: begin
          state_q <= S_WR;
          strb_q  <= decode(S_WR);
        end
        S_WR: begin
          if (pre_idx_q != LAST_PRE) begin
            pre_idx_q <= pre_idx_q + 1'b1;
            state_q   <= S_RD;
            strb_q    <= decode(S_RD);
          end else if (post_idx_q != LAST_POST) begin
            post_idx_q <= post_idx_q + 1'b1;
            state_q    <= S_RD_POST;
            strb_q     <= decode(S_RD_POST);
          end else begin
            state_q <= S_FIN;
            strb_q  <= decode(S_FIN);
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
          strb_q  <= decode(S_IDLE);
        end
        default: begin
          state_q <= S_IDLE;
          strb_q  <= '0;
        end
      endcase
    end
  end

  // Write-back phase: memory read data flows straight through to the update unit.
  assign wr_fire = strb_q.wr & wr_en;
  assign syn_cs  = strb_q.rd | wr_fire;

  assign bus.busy_o           = strb_q.busy;
  assign bus.done_o           = strb_q.done;

  assign bus.post_cnt_re_o    = strb_q.post_re;
  assign bus.post_cnt_addr_o  = strb_q.post_re ? post_idx_q : '0;
  assign bus.pre_cnt_re_o     = strb_q.rd;
  assign bus.pre_cnt_addr_o   = strb_q.rd ? pre_idx_q : '0;

  assign bus.syn_cs_o         = syn_cs;
  assign bus.syn_we_o         = wr_fire;
  assign bus.syn_addr_o       = syn_cs ? {post_idx_q, pre_idx_q} : '0;
  assign bus.syn_wdata_o      = wr_fire ? bus.upd_wsyn_new_i : {WEIGHT_WIDTH{1'b0}};

  assign bus.upd_tref_event_o = wr_fire;
  assign bus.upd_is_pos_o     = is_pos_q;
  assign bus.upd_is_train_o   = strb_q.busy;
  assign bus.upd_pre_cnt_o    = strb_q.wr ? bus.pre_cnt_rdata_i : {PRE_CNT_WIDTH{1'b0}};
  assign bus.upd_post_cnt_o   = strb_q.wr ? post_cnt_q : {POST_CNT_WIDTH{1'b0}};
  assign bus.upd_wsyn_curr_o  = strb_q.wr ? bus.syn_rdata_i : {WEIGHT_WIDTH{1'b0}};

endmodule
`default_nettype wire

// File: tb/tb_ffstdp_weight_sweep.sv
`default_nettype none
// ============================================================================
// Module   : tb_ffstdp_weight_sweep
// Brief    : Directed bench for ffstdp_weight_sweep with an array-level model
//            of the sweep (write list, BUSY length, DONE cycle).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ffstdp_weight_sweep;
  localparam int PAW   = 2;
  localparam int NPOST = 2;
  localparam int POAW  = 1;
  localparam int PCW   = 8;
  localparam int QCW   = 7;
  localparam int WW    = 8;
  localparam int NPRE  = 1 << PAW;
  localparam int NSYN  = NPOST * NPRE;
`ifdef FFSTDP_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ffstdp_weight_sweep_if #(.PRE_ADDR_W(PAW), .POST_ADDR_W(POAW), .PRE_CNT_WIDTH(PCW),
                           .POST_CNT_WIDTH(QCW), .WEIGHT_WIDTH(WW)) bus ();

  ffstdp_weight_sweep #(.PRE_ADDR_W(PAW), .N_POST(NPOST), .POST_ADDR_W(POAW),
                        .PRE_CNT_WIDTH(PCW), .POST_CNT_WIDTH(QCW), .WEIGHT_WIDTH(WW))
    dut (.clk(clk), .rst(rst), .bus(bus));

  // Environment: count memories, synapse SRAM, update stub NEW = CURR + 1
  logic [WW-1:0]  syn_mem   [NSYN];
  logic [WW-1:0]  load_vals [NSYN];
  logic           load_en = 1'b0;
  logic [QCW-1:0] post_mem  [NPOST];
  logic [PCW-1:0] pre_mem   [NPRE];

  assign bus.upd_wsyn_new_i = bus.upd_wsyn_curr_o + WW'(1);

  always @(posedge clk) begin
    if (load_en) syn_mem <= load_vals;
    else if (bus.syn_cs_o && bus.syn_we_o) syn_mem[bus.syn_addr_o] <= bus.syn_wdata_o;
    if (bus.syn_cs_o && !bus.syn_we_o) bus.syn_rdata_i <= syn_mem[bus.syn_addr_o];
    if (bus.post_cnt_re_o) bus.post_cnt_rdata_i <= post_mem[bus.post_cnt_addr_o];
    if (bus.pre_cnt_re_o)  bus.pre_cnt_rdata_i  <= pre_mem[bus.pre_cnt_addr_o];
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", n, act, exp);
    end
  endtask

  // Array-level model of one sweep
  typedef struct {
    int addr;
    int old_v;
    int new_v;
  } wr_t;
  wr_t     exp_q[$];
  int      exp_mem [NSYN];
  int      exp_busy = 0;
  bit      exp_pos  = 1'b0;
  bit      chk_on   = 1'b0;
  int      t        = 0;
  int      wr_idx   = 0;
  bit      eb;

  function automatic logic [45:0] all_outs();
    return {bus.busy_o, bus.done_o, bus.post_cnt_re_o, bus.post_cnt_addr_o, bus.pre_cnt_re_o,
            bus.pre_cnt_addr_o, bus.syn_cs_o, bus.syn_we_o, bus.syn_addr_o, bus.syn_wdata_o,
            bus.upd_tref_event_o, bus.upd_is_pos_o, bus.upd_is_train_o, bus.upd_pre_cnt_o,
            bus.upd_post_cnt_o, bus.upd_wsyn_curr_o};
  endfunction

  // Per-cycle compare against the model; t counts cycles after the START edge
  always @(negedge clk) begin
    if (!chk_on) begin
      t      = 0;
      wr_idx = 0;
    end else begin
      t  = t + 1;
      eb = (t >= 1) && (t <= exp_busy);
      chk("busy", bus.busy_o, eb);
      chk("done", bus.done_o, t == exp_busy + 1);
      chk("is_train", bus.upd_is_train_o, eb);
      if (eb) chk("is_pos", bus.upd_is_pos_o, exp_pos);
      else chk("idle_access", {bus.post_cnt_re_o, bus.pre_cnt_re_o, bus.syn_cs_o,
                               bus.upd_tref_event_o}, 4'b0000);
      if (bus.syn_cs_o && bus.syn_we_o) begin
        if (wr_idx >= exp_q.size()) begin
          total++;
          bad++;
          $display("FAIL extra_write: got addr=%0d want no write", bus.syn_addr_o);
        end else begin
          chk("wr_addr", bus.syn_addr_o, exp_q[wr_idx].addr);
          chk("wr_data", bus.syn_wdata_o, exp_q[wr_idx].new_v);
          chk("upd_curr", bus.upd_wsyn_curr_o, exp_q[wr_idx].old_v);
          chk("upd_post", bus.upd_post_cnt_o, post_mem[exp_q[wr_idx].addr / NPRE]);
          chk("upd_pre", bus.upd_pre_cnt_o, pre_mem[exp_q[wr_idx].addr % NPRE]);
          chk("tref", bus.upd_tref_event_o, 1);
          wr_idx = wr_idx + 1;
        end
      end
    end
  end

  task automatic preload_ramp();
    for (int a = 0; a < NSYN; a++) load_vals[a] = WW'(a);
    @(negedge clk);
    load_en = 1'b1;
    @(posedge clk);
    #1 load_en = 1'b0;
  endtask

  task automatic run_sweep(input bit pos, input bit train, input bit poke, input int abort_c,
                           output int nwr, output int left);
    int a;
    exp_q.delete();
    for (int i = 0; i < NSYN; i++) exp_mem[i] = int'(syn_mem[i]);
    exp_busy = 0;
    if (train) begin
      for (int p = 0; p < NPOST; p++) begin
        if (SKIP && post_mem[p] == 0) begin
          exp_busy += 2;
        end else begin
          exp_busy += 2 + 2 * NPRE;
          for (int i = 0; i < NPRE; i++) begin
            if (!(SKIP && pre_mem[i] == 0)) begin
              a = p * NPRE + i;
              exp_q.push_back('{a, exp_mem[a], (exp_mem[a] + 1) % 256});
              exp_mem[a] = (exp_mem[a] + 1) % 256;
            end
          end
        end
      end
    end
    nwr     = exp_q.size();
    left    = 0;
    exp_pos = pos;
    @(negedge clk);
    bus.start_i       = 1'b1;
    bus.is_pos_in_i   = pos;
    bus.is_train_in_i = train;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    chk_on = 1'b1;
    for (int c = 1; c <= exp_busy + 3; c++) begin
      @(posedge clk);
      #1 bus.start_i = 1'b0;
      if (c == abort_c) begin
        chk("abort_in_wr", bus.syn_we_o, 1);
        chk("abort_addr", bus.syn_addr_o, exp_q[wr_idx].addr);
        #1 rst = 1'b1;
        #1 chk("async_rst_outs", all_outs(), '0);
        left   = exp_q.size() - wr_idx;
        chk_on = 1'b0;
        for (int k = wr_idx; k < exp_q.size(); k++) exp_mem[exp_q[k].addr] = exp_q[k].old_v;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        break;
      end
      if (poke && (c == 5 || c == exp_busy)) begin
        bus.start_i       = 1'b1;
        bus.is_pos_in_i   = ~pos;
        bus.is_train_in_i = 1'b1;
      end
    end
    if (chk_on) begin
      left   = exp_q.size() - wr_idx;
      chk_on = 1'b0;
      chk("writes_left", left, 0);
    end
    for (int i = 0; i < NSYN; i++) chk($sformatf("mem[%0d]", i), syn_mem[i], exp_mem[i]);
  endtask

  initial begin
    int nwr;
    int left;
    bus.start_i       = 1'b0;
    bus.is_pos_in_i   = 1'b0;
    bus.is_train_in_i = 1'b0;
    for (int p = 0; p < NPOST; p++) post_mem[p] = QCW'(1);
    for (int i = 0; i < NPRE; i++) pre_mem[i] = PCW'(1);
    repeat (3) @(posedge clk);
    #1 chk("reset_outs", all_outs(), '0);
    @(negedge clk);
    rst = 1'b0;

    // Basic sweep: ramp 0..7 becomes 1..8
    preload_ramp();
    run_sweep(1'b0, 1'b1, 1'b0, 0, nwr, left);
    chk("basic_busy_len", exp_busy, 20);
    chk("basic_nwr", nwr, 8);
    for (int a = 0; a < NSYN; a++) chk("basic_mem_lit", syn_mem[a], a + 1);

    // No training: DONE one cycle after START, nothing touched
    run_sweep(1'b0, 1'b0, 1'b0, 0, nwr, left);
    chk("notrain_nwr", nwr, 0);
    for (int a = 0; a < NSYN; a++) chk("notrain_mem_lit", syn_mem[a], a + 1);

    // Polarity latched; START mid-sweep and in FIN ignored
    run_sweep(1'b1, 1'b1, 1'b1, 0, nwr, left);
    chk("poke_busy_len", exp_busy, 20);
    for (int a = 0; a < NSYN; a++) chk("poke_mem_lit", syn_mem[a], a + 2);

    // Async reset in WR of synapse 5, then a fresh sweep restarts at 0
    bus.is_pos_in_i = 1'b0;
    preload_ramp();
    run_sweep(1'b0, 1'b1, 1'b0, 15, nwr, left);
    chk("abort_left", left, 3);
    for (int a = 0; a < NSYN; a++) chk("abort_mem_lit", syn_mem[a], (a < 5) ? a + 1 : a);
    run_sweep(1'b0, 1'b1, 1'b0, 0, nwr, left);
    for (int a = 0; a < NSYN; a++) chk("restart_mem_lit", syn_mem[a], (a < 5) ? a + 2 : a + 1);

    // Zero counts: post 0 and pre 2
    post_mem[0] = '0;
    pre_mem[2]  = '0;
    preload_ramp();
    run_sweep(1'b1, 1'b1, 1'b0, 0, nwr, left);
    if (SKIP) begin
      chk("skip_busy_len", exp_busy, 12);
      chk("skip_nwr", nwr, 3);
      chk("skip_mem6", syn_mem[6], 6);
      chk("skip_mem0", syn_mem[0], 0);
    end else begin
      chk("noskip_busy_len", exp_busy, 20);
      chk("noskip_nwr", nwr, 8);
      chk("noskip_mem6", syn_mem[6], 7);
      chk("noskip_mem0", syn_mem[0], 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
`default_nettype wire
